// File: rtl/mem_dump_streamer_pkg.sv
// Shared types and helpers for the memory dump streamer: FSM state encoding,
// default bytes-per-word and small byte-count arithmetic helpers.
package mem_dump_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SEND,
        ST_FIN,
        ST_DRAIN
    } dump_state_e;

    localparam int BPW = 4;

    // Byte offset of an address inside its word; nonzero means misaligned.
    function automatic int unsigned byte_offset(input int unsigned addr, input int unsigned bpw);
        return addr % bpw;
    endfunction

    // Bytes carried by the next word given the bytes still to be streamed.
    function automatic int unsigned word_bytes(input int unsigned remaining, input int unsigned bpw);
        return (remaining < bpw) ? remaining : bpw;
    endfunction

endpackage

// File: rtl/mem_dump_streamer_if.sv
// Bundles the word-wide memory read port and the byte stream port of the dump streamer.
interface mem_dump_streamer_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              tx_valid_o;
    logic [7:0]        tx_data_o;
    logic              tx_last_o;
    logic              tx_ready_i;

    modport master (
        output mem_req_o, mem_addr_o, tx_valid_o, tx_data_o, tx_last_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, tx_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, tx_valid_o, tx_data_o, tx_last_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, tx_ready_i
    );
endinterface

// File: rtl/mem_dump_streamer_serializer.sv
// Holds one memory word and emits its bytes little-endian on a valid/ready port,
// flagging the final byte of the dump and reporting when the word is used up.
module mem_dump_streamer_serializer
    import mem_dump_streamer_pkg::*;
#(
    parameter int DATA_W = 8 * BPW,
    localparam int NB    = DATA_W / 8,
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic [IDX_W-1:0]  last_idx,
    input  logic              last_word,
    input  logic              flush,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_last,
    output logic              word_done
);

    logic [DATA_W-1:0] buf_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  last_idx_q;
    logic              valid_q;
    logic              last_word_q;
    logic              fire;
    logic              at_last;

    assign fire      = valid_q & tx_ready;
    assign at_last   = (idx_q == last_idx_q);
    assign word_done = fire & at_last;

    // The byte index only moves on an accepted byte, so data and last stay put during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '0;
            idx_q       <= '0;
            last_idx_q  <= '0;
            valid_q     <= 1'b0;
            last_word_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else if (load) begin
            buf_q       <= word;
            idx_q       <= '0;
            last_idx_q  <= last_idx;
            last_word_q <= last_word;
            valid_q     <= 1'b1;
        end else if (fire) begin
            if (at_last) begin
                valid_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign tx_valid = valid_q;
    assign tx_data  = buf_q[8*idx_q +: 8];
    assign tx_last  = valid_q & last_word_q & at_last;

endmodule

// File: rtl/mem_dump_streamer.sv
// Reads a byte range out of main memory one word at a time (single outstanding read)
// and streams it little-endian as bytes; supports abort and reports misaligned starts.
module mem_dump_streamer
    import mem_dump_streamer_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8 * BPW,
    parameter int LEN_W  = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  byte_len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    mem_dump_streamer_if.master bus
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic              abort_q;
    logic              err_q;

    logic              start_ok, start_bad, load_word, next_word, flush;
    logic              word_done;
    logic [LEN_W-1:0]  word_len;
    logic [IDX_W-1:0]  last_idx;
    logic              last_word;
    logic              ser_valid, ser_last;
    logic [7:0]        ser_data;

    assign word_len  = LEN_W'(word_bytes(32'(remaining_q), NB));
    assign last_idx  = IDX_W'(word_bytes(32'(remaining_q), NB) - 1);
    assign last_word = (remaining_q <= LEN_W'(NB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An abort seen while a request is still pending is remembered until the grant,
    // since the request cannot be withdrawn and its read data must be drained.
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        load_word = 1'b0;
        next_word = 1'b0;
        flush     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (byte_offset(32'(base_addr_i), NB) != 0) begin
                        start_bad = 1'b1;
                    end else if (byte_len_i == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        start_ok = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_gnt_i) begin
                    state_d = (abort_i | abort_q) ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort_i) begin
                    state_d = bus.mem_rvalid_i ? ST_IDLE : ST_DRAIN;
                end else if (bus.mem_rvalid_i) begin
                    load_word = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else if (word_done) begin
                    if (remaining_q == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        next_word = 1'b1;
                        state_d   = ST_REQ;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.mem_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The remaining count is charged when a word is loaded, so it reads zero
    // while the final word is still being sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q   <= start_bad;
            abort_q <= (state_q == ST_REQ) & ~bus.mem_gnt_i & (abort_i | abort_q);
            if (start_ok) begin
                addr_q      <= base_addr_i;
                remaining_q <= byte_len_i;
            end else begin
                if (load_word) begin
                    remaining_q <= remaining_q - word_len;
                end
                if (next_word) begin
                    addr_q <= addr_q + ADDR_W'(NB);
                end
            end
        end
    end

    mem_dump_streamer_serializer #(
        .DATA_W(DATA_W)
    ) u_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_word),
        .word     (bus.mem_rdata_i),
        .last_idx (last_idx),
        .last_word(last_word),
        .flush    (flush),
        .tx_ready (bus.tx_ready_i),
        .tx_valid (ser_valid),
        .tx_data  (ser_data),
        .tx_last  (ser_last),
        .word_done(word_done)
    );

    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_FIN);
    assign err_o          = err_q;
    assign bus.mem_req_o  = (state_q == ST_REQ);
    assign bus.mem_addr_o = addr_q;
    assign bus.tx_valid_o = ser_valid;
    assign bus.tx_data_o  = ser_data;
    assign bus.tx_last_o  = ser_last;

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Self-checking bench for mem_dump_streamer: byte-array memory model with random
// grant/latency, random sink backpressure, and an expected stream built from the memory.
module tb_mem_dump_streamer;

    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 32;
    localparam int LEN_W    = 18;
    localparam int MEM_SIZE = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic              abort_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [LEN_W-1:0]  byte_len_i;
    logic              busy_o, done_o, err_o;

    mem_dump_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_dump_streamer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .base_addr_i(base_addr_i),
        .byte_len_i (byte_len_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]        mem [0:MEM_SIZE-1];
    logic [8:0]        rx_q[$];
    logic [8:0]        exp_q[$];
    logic [ADDR_W-1:0] req_log[$];

    int          checks = 0;
    int          failures = 0;
    int unsigned ready_pct = 100;
    int unsigned gnt_max = 0;
    int unsigned lat_min = 0;
    int unsigned lat_max = 0;
    int          done_cnt, err_cnt, tx_cnt, req_hi_cnt, stall_viol;

    bit          resp_pend = 1'b0;
    int unsigned pend_addr, pend_wait, gnt_wait;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;

    // Memory responder, sink and monitor all act on the falling edge.
    initial begin
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        bus.tx_ready_i   = 1'b0;
        gnt_wait         = 0;
        forever begin
            @(negedge clk);
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            if (!rst_n) begin
                resp_pend = 1'b0;
                gnt_wait  = 0;
            end else if (resp_pend) begin
                if (pend_wait == 0) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = {mem[pend_addr+3], mem[pend_addr+2], mem[pend_addr+1], mem[pend_addr]};
                    resp_pend        = 1'b0;
                end else begin
                    pend_wait--;
                end
            end else if (bus.mem_req_o) begin
                if (gnt_wait == 0) begin
                    bus.mem_gnt_i = 1'b1;
                    resp_pend     = 1'b1;
                    pend_addr     = 32'(bus.mem_addr_o);
                    pend_wait     = $urandom_range(lat_max, lat_min);
                    gnt_wait      = $urandom_range(gnt_max, 0);
                    req_log.push_back(bus.mem_addr_o);
                end else begin
                    gnt_wait--;
                end
            end
            bus.tx_ready_i = ($urandom_range(99, 0) < ready_pct);
            #1;
            if (!rst_n || abort_i) begin
                prev_stall = 1'b0;
            end else begin
                if (done_o) done_cnt++;
                if (err_o) err_cnt++;
                if (bus.tx_valid_o) tx_cnt++;
                if (bus.mem_req_o) req_hi_cnt++;
                if (prev_stall && (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== prev_data ||
                                   bus.tx_last_o !== prev_last)) stall_viol++;
                if (bus.tx_valid_o && bus.tx_ready_i) rx_q.push_back({bus.tx_last_o, bus.tx_data_o});
                prev_stall = bus.tx_valid_o && !bus.tx_ready_i;
                prev_data  = bus.tx_data_o;
                prev_last  = bus.tx_last_o;
            end
        end
    end

    // Expected stream: len bytes read from memory starting at base, wrapping the address space.
    task automatic build_expected(input int unsigned base, input int unsigned len);
        exp_q.delete();
        for (int unsigned i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), mem[(base + i) % MEM_SIZE]});
        end
    endtask

    task automatic fill_random(input int unsigned base, input int unsigned len);
        for (int unsigned i = 0; i < len; i++) begin
            mem[(base + i) % MEM_SIZE] = 8'($urandom);
        end
    endtask

    task automatic applyStimulus(input int unsigned base, input int unsigned len);
        @(negedge clk);
        #2;
        rx_q.delete();
        req_log.delete();
        done_cnt    = 0;
        err_cnt     = 0;
        tx_cnt      = 0;
        req_hi_cnt  = 0;
        stall_viol  = 0;
        base_addr_i = ADDR_W'(base);
        byte_len_i  = LEN_W'(len);
        start_i     = 1'b1;
        @(negedge clk);
        #2;
        start_i = 1'b0;
    endtask

    task automatic run_dump(input int unsigned base, input int unsigned len, input string name);
        applyStimulus(base, len);
        for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("[TB] FAIL %s_timeout done pulses got=%0d want=1", name, done_cnt);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy_o, done_o, err_o, bus.mem_req_o, bus.tx_valid_o, bus.tx_last_o} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%b want=000000",
                     {busy_o, done_o, err_o, bus.mem_req_o, bus.tx_valid_o, bus.tx_last_o});
        end
        checks++;
        if (bus.tx_data_o !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_tx_data got=%h want=00", bus.tx_data_o);
        end
        checks++;
        if (bus.mem_addr_o !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mem_addr got=%h want=0", bus.mem_addr_o);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) mem[32'h100 + i] = 8'(i);
        ready_pct = 100; gnt_max = 0; lat_min = 0; lat_max = 0;
        build_expected(32'h100, 8);
        run_dump(32'h100, 8, "basic");
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL basic_count got=%0d want=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL basic_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || req_log.size() != 2) begin
            failures++;
            $display("[TB] FAIL basic_done_reqs got=%0d/%0d want=1/2", done_cnt, req_log.size());
        end
    endtask

    task automatic test_two_words();
        {mem[32'h203], mem[32'h202], mem[32'h201], mem[32'h200]} = 32'h44332211;
        {mem[32'h207], mem[32'h206], mem[32'h205], mem[32'h204]} = 32'h88776655;
        build_expected(32'h200, 6);
        run_dump(32'h200, 6, "words");
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL words_count got=%0d want=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL words_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rx_q.size() < 6 || rx_q[5] !== 9'h166) begin
            failures++;
            $display("[TB] FAIL words_last got=%0d bytes want last=166", rx_q.size());
        end
        checks++;
        if (req_log.size() != 2 || req_hi_cnt != 2) begin
            failures++;
            $display("[TB] FAIL words_reqs got=%0d/%0d want=2/2", req_log.size(), req_hi_cnt);
        end
    endtask

    task automatic test_backpressure();
        int unsigned base;
        base = $urandom_range(MEM_SIZE - 64, 0) & ~32'h3;
        fill_random(base, 32);
        ready_pct = 45; gnt_max = 2; lat_min = 0; lat_max = 3;
        build_expected(base, 32);
        run_dump(base, 32, "bp");
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL bp_count got=%0d want=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL bp_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stall_viol != 0 || req_log.size() != 8) begin
            failures++;
            $display("[TB] FAIL bp_stall_reqs got=%0d/%0d want=0/8", stall_viol, req_log.size());
        end
    endtask

    task automatic test_wrap();
        fill_random(32'h1FFFC, 8);
        ready_pct = 100; gnt_max = 0; lat_min = 0; lat_max = 0;
        build_expected(32'h1FFFC, 8);
        run_dump(32'h1FFFC, 8, "wrap");
        checks++;
        if (req_log.size() != 2 || req_log[0] !== 17'h1FFFC || req_log[1] !== 17'h00000) begin
            failures++;
            $display("[TB] FAIL wrap_addr got=%0d reqs want=2 (1fffc,00000)", req_log.size());
        end
        checks++;
        if (rx_q != exp_q) begin
            failures++;
            $display("[TB] FAIL wrap_stream got=%0d bytes want=%0d matching", rx_q.size(), exp_q.size());
        end
    endtask

    task automatic test_start_errors();
        applyStimulus(32'h102, 4);
        repeat (5) @(negedge clk);
        #2;
        checks++;
        if (err_cnt != 1 || req_hi_cnt != 0 || busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL misaligned got err=%0d req=%0d busy=%b want 1/0/0", err_cnt, req_hi_cnt, busy_o);
        end
        applyStimulus(32'h100, 0);
        repeat (5) @(negedge clk);
        #2;
        checks++;
        if (done_cnt != 1 || req_hi_cnt != 0 || tx_cnt != 0 || err_cnt != 0) begin
            failures++;
            $display("[TB] FAIL zero_len got done=%0d req=%0d tx=%0d err=%0d want 1/0/0/0",
                     done_cnt, req_hi_cnt, tx_cnt, err_cnt);
        end
    endtask

    task automatic test_abort_wait();
        bit busy_during;
        fill_random(32'h300, 8);
        ready_pct = 100; gnt_max = 0; lat_min = 5; lat_max = 5;
        applyStimulus(32'h300, 8);
        for (int c = 0; c < 20 && !resp_pend; c++) begin
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        #2;
        abort_i = 1'b1;
        @(negedge clk);
        #2;
        abort_i = 1'b0;
        busy_during = busy_o;
        for (int c = 0; c < 30 && busy_o; c++) begin
            @(negedge clk);
            #2;
        end
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (busy_during !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_busy got during=%b after=%b want 1/0", busy_during, busy_o);
        end
        checks++;
        if (tx_cnt != 0 || done_cnt != 0 || req_log.size() != 1 || resp_pend) begin
            failures++;
            $display("[TB] FAIL abort_quiet got tx=%0d done=%0d reqs=%0d want 0/0/1",
                     tx_cnt, done_cnt, req_log.size());
        end
        lat_min = 0; lat_max = 0;
    endtask

    task automatic checkOutput();
        checks++;
        if ({busy_o, done_o, err_o, bus.mem_req_o, bus.tx_valid_o, bus.tx_last_o} !== 6'b0 ||
            bus.tx_data_o !== 8'h00 || bus.mem_addr_o !== '0) begin
            failures++;
            $display("[TB] FAIL rst_mid_send got ctrl=%b data=%h addr=%h want all 0",
                     {busy_o, done_o, err_o, bus.mem_req_o, bus.tx_valid_o, bus.tx_last_o},
                     bus.tx_data_o, bus.mem_addr_o);
        end
    endtask

    task automatic test_reset_mid_send();
        fill_random(32'h400, 8);
        ready_pct = 0;
        applyStimulus(32'h400, 8);
        for (int c = 0; c < 50 && !bus.tx_valid_o; c++) begin
            @(negedge clk);
            #2;
        end
        checks++;
        if (bus.tx_valid_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_reach_send got tx_valid=%b want 1", bus.tx_valid_o);
        end
        rst_n = 1'b0;
        #1;
        checkOutput();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        ready_pct = 100;
        repeat (4) @(negedge clk);
        #2;
        checks++;
        if (busy_o !== 1'b0 || bus.tx_valid_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_after got busy=%b tx=%b req=%b want 0/0/0",
                     busy_o, bus.tx_valid_o, bus.mem_req_o);
        end
    endtask

    task automatic test_random();
        int unsigned base, len;
        for (int n = 0; n < 5; n++) begin
            base = $urandom_range(MEM_SIZE - 1, 0) & ~32'h3;
            len  = $urandom_range(40, 1);
            fill_random(base, len);
            ready_pct = 70; gnt_max = 2; lat_min = 0; lat_max = 3;
            build_expected(base, len);
            run_dump(base, len, "rand");
            checks++;
            if (rx_q != exp_q) begin
                failures++;
                $display("[TB] FAIL rand%0d_stream base=%h len=%0d got=%0d bytes want=%0d matching",
                         n, base, len, rx_q.size(), exp_q.size());
            end
            checks++;
            if (req_log.size() != (len + 3) / 4 || done_cnt != 1 || stall_viol != 0) begin
                failures++;
                $display("[TB] FAIL rand%0d_ctrl got reqs=%0d done=%0d stall=%0d want %0d/1/0",
                         n, req_log.size(), done_cnt, stall_viol, (len + 3) / 4);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        base_addr_i = '0;
        byte_len_i  = '0;
        repeat (3) @(negedge clk);
        #2;
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_basic();
        test_two_words();
        test_backpressure();
        test_wrap();
        test_start_errors();
        test_abort_wait();
        test_reset_mid_send();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
